// File: rtl/fb_arb_pkg.sv
// -----------------------------------------------------------------------------
// fb_arb_pkg
// Shared types and defaults for the frame-buffer access arbiter.
//   owner_e : who owns the RAM read that returns in the next cycle
//   grant_e : which requester drives the single RAM port this cycle
//   FB_ADDR_W / FB_DATA_W : default frame-buffer address ({y[6:0], x[7:0]})
//                           and pixel widths
// -----------------------------------------------------------------------------
package fb_arb_pkg;

  localparam int FB_ADDR_W = 15;
  localparam int FB_DATA_W = 1;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VGA  = 2'd1,
    OWN_CPU  = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    G_IDLE   = 2'd0,
    G_VGA    = 2'd1,
    G_CPU_RD = 2'd2,
    G_DRAIN  = 2'd3
  } grant_e;

endpackage

// File: rtl/fb_wr_fifo.sv
// -----------------------------------------------------------------------------
// fb_wr_fifo
// Small synchronous FIFO holding posted CPU writes as {addr, data} words.
// The head entry is presented combinationally so the arbiter can drive it
// onto the RAM port in the same cycle it pops it.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   push, push_data   enqueue request and entry (ignored when full)
//   pop               dequeue request (ignored when empty)
//   head_data         oldest entry
//   full, empty       occupancy flags
//   level             current occupancy, one bit wider than the pointers
// -----------------------------------------------------------------------------
module fb_wr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   level_reg;
  logic             do_push;
  logic             do_pop;

  assign full      = (level_reg == (PTR_W+1)'(DEPTH));
  assign empty     = (level_reg == '0);
  assign level     = level_reg;
  assign head_data = mem_reg[rd_ptr_reg];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  // Storage is not reset: the pointers/level alone define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg] <= push_data;
    end
  end

  // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

endmodule

// File: rtl/fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// fb_access_arbiter
// Shares the single frame-buffer RAM port between VGA pixel reads (highest
// priority), CPU reads and posted CPU writes. Writes sit in a small FIFO and
// drain into otherwise idle cycles; CPU reads wait for the FIFO to empty so
// the CPU always sees its own earlier writes.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   vga_rd_req/addr -> vga_rd_data/valid   pixel read, response next cycle
//   cpu_wr_req/addr/data, cpu_wr_ready     posted write, accepted when ready
//   cpu_rd_req/addr -> cpu_rd_data/valid   level read request
//   mem_en/we/addr/wdata, mem_rdata        RAM port (1-cycle sync read)
//   fifo_level                             posted-write FIFO occupancy
// -----------------------------------------------------------------------------
module fb_access_arbiter
  import fb_arb_pkg::*;
#(
  parameter int ADDR_W     = FB_ADDR_W,
  parameter int DATA_W     = FB_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        vga_rd_req,
  input  logic [ADDR_W-1:0]           vga_rd_addr,
  output logic [DATA_W-1:0]           vga_rd_data,
  output logic                        vga_rd_valid,
  input  logic                        cpu_wr_req,
  input  logic [ADDR_W-1:0]           cpu_wr_addr,
  input  logic [DATA_W-1:0]           cpu_wr_data,
  output logic                        cpu_wr_ready,
  input  logic                        cpu_rd_req,
  input  logic [ADDR_W-1:0]           cpu_rd_addr,
  output logic [DATA_W-1:0]           cpu_rd_data,
  output logic                        cpu_rd_valid,
  output logic                        mem_en,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int ENT_W = ADDR_W + DATA_W;

  grant_e              grant;
  owner_e              owner_reg;
  owner_e              owner_next;
  logic                cpu_rd_out_reg;
  logic [ADDR_W-1:0]   last_addr_reg;
  logic [DATA_W-1:0]   last_wdata_reg;
  logic [ADDR_W-1:0]   addr_next;
  logic [DATA_W-1:0]   wdata_next;

  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_push;
  logic                fifo_pop;
  logic [ENT_W-1:0]    fifo_head;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;

  assign fifo_push    = cpu_wr_req && !fifo_full;
  assign fifo_pop     = (grant == G_DRAIN);
  assign cpu_wr_ready = !fifo_full;
  assign head_addr    = fifo_head[ENT_W-1:DATA_W];
  assign head_data    = fifo_head[DATA_W-1:0];

  fb_wr_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data ({cpu_wr_addr, cpu_wr_data}),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Fixed-priority grant. The outstanding flag stops a still-held
  // cpu_rd_req from being granted again in its response cycle.
  always_comb begin
    grant = G_IDLE;
    if (vga_rd_req) begin
      grant = G_VGA;
    end else if (cpu_rd_req && fifo_empty && !cpu_rd_out_reg) begin
      grant = G_CPU_RD;
    end else if (!fifo_empty) begin
      grant = G_DRAIN;
    end
  end

  // Address/data for the RAM; idle cycles hold the last driven values.
  always_comb begin
    addr_next  = last_addr_reg;
    wdata_next = last_wdata_reg;
    owner_next = OWN_NONE;
    case (grant)
      G_VGA: begin
        addr_next  = vga_rd_addr;
        owner_next = OWN_VGA;
      end
      G_CPU_RD: begin
        addr_next  = cpu_rd_addr;
        owner_next = OWN_CPU;
      end
      G_DRAIN: begin
        addr_next  = head_addr;
        wdata_next = head_data;
      end
      default: ;
    endcase
  end

  // Enables are forced low while reset is asserted, independent of requests.
  assign mem_en    = rst_n && (grant != G_IDLE);
  assign mem_we    = rst_n && (grant == G_DRAIN);
  assign mem_addr  = addr_next;
  assign mem_wdata = wdata_next;

  // Read data is simply the RAM output; the owner register decides which
  // requester's strobe fires.
  assign vga_rd_data  = mem_rdata;
  assign cpu_rd_data  = mem_rdata;
  assign vga_rd_valid = (owner_reg == OWN_VGA);
  assign cpu_rd_valid = (owner_reg == OWN_CPU);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg      <= OWN_NONE;
      cpu_rd_out_reg <= 1'b0;
      last_addr_reg  <= '0;
      last_wdata_reg <= '0;
    end else begin
      owner_reg <= owner_next;
      if (grant == G_CPU_RD) begin
        cpu_rd_out_reg <= 1'b1;
      end else if (cpu_rd_valid) begin
        cpu_rd_out_reg <= 1'b0;
      end
      last_addr_reg  <= addr_next;
      last_wdata_reg <= wdata_next;
    end
  end

endmodule

// File: tb/tb_fb_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fb_access_arbiter
// Directed bench for fb_access_arbiter with a behavioural 1-cycle RAM.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 3 time units after the edge (or at the falling edge for reset checks).
// -----------------------------------------------------------------------------
module tb_fb_access_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 1;
  localparam int FIFO_DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                vga_rd_req;
  logic [ADDR_W-1:0]   vga_rd_addr;
  logic [DATA_W-1:0]   vga_rd_data;
  logic                vga_rd_valid;
  logic                cpu_wr_req;
  logic [ADDR_W-1:0]   cpu_wr_addr;
  logic [DATA_W-1:0]   cpu_wr_data;
  logic                cpu_wr_ready;
  logic                cpu_rd_req;
  logic [ADDR_W-1:0]   cpu_rd_addr;
  logic [DATA_W-1:0]   cpu_rd_data;
  logic                cpu_rd_valid;
  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;
  logic [2:0]          fifo_level;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;
  int wr_snap;

  bit ram [0:(1<<ADDR_W)-1];

  logic [ADDR_W-1:0] fill_addr [5] = '{15'h0100, 15'h0101, 15'h0102, 15'h0103, 15'h0104};
  logic              fill_data [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
  logic [ADDR_W-1:0] pp_addr   [4] = '{15'h0200, 15'h0201, 15'h0202, 15'h0203};
  logic              pp_data   [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  always #5 clk = ~clk;

  fb_access_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .vga_rd_req   (vga_rd_req),
    .vga_rd_addr  (vga_rd_addr),
    .vga_rd_data  (vga_rd_data),
    .vga_rd_valid (vga_rd_valid),
    .cpu_wr_req   (cpu_wr_req),
    .cpu_wr_addr  (cpu_wr_addr),
    .cpu_wr_data  (cpu_wr_data),
    .cpu_wr_ready (cpu_wr_ready),
    .cpu_rd_req   (cpu_rd_req),
    .cpu_rd_addr  (cpu_rd_addr),
    .cpu_rd_data  (cpu_rd_data),
    .cpu_rd_valid (cpu_rd_valid),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .fifo_level   (fifo_level)
  );

  // Synchronous single-port RAM, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we === 1'b1) begin
        ram[mem_addr] = mem_wdata[0];
        wr_count      = wr_count + 1;
      end else begin
        mem_rdata <= ram[mem_addr];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    vga_rd_req  = 1'b0;
    vga_rd_addr = '0;
    cpu_wr_req  = 1'b0;
    cpu_wr_addr = '0;
    cpu_wr_data = '0;
    cpu_rd_req  = 1'b0;
    cpu_rd_addr = '0;
    ram[15'h0123] = 1'b1;

    // ---------------- reset values ----------------
    #2;
    chk("rst_vga_valid", vga_rd_valid, 0);
    chk("rst_cpu_valid", cpu_rd_valid, 0);
    chk("rst_mem_en",    mem_en, 0);
    chk("rst_mem_we",    mem_we, 0);
    chk("rst_level",     fifo_level, 0);
    chk("rst_ready",     cpu_wr_ready, 1);
    chk("rst_mem_addr",  mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    @(posedge clk);
    cyc();
    rst_n = 1'b1;

    // ---------------- VGA only ----------------
    cyc();
    vga_rd_req  = 1'b1;
    vga_rd_addr = 15'h0123;
    #2;
    chk("vga_mem_en",   mem_en, 1);
    chk("vga_mem_we",   mem_we, 0);
    chk("vga_mem_addr", mem_addr, 15'h0123);
    cyc();
    vga_rd_req = 1'b0;
    #2;
    chk("vga_valid",      vga_rd_valid, 1);
    chk("vga_data",       vga_rd_data, 1);
    chk("vga_cpu_quiet",  cpu_rd_valid, 0);
    chk("vga_idle_en",    mem_en, 0);
    chk("vga_idle_hold",  mem_addr, 15'h0123);
    cyc();
    #2;
    chk("vga_valid_once", vga_rd_valid, 0);

    // ---------------- FIFO fill under VGA load ----------------
    vga_rd_addr = 15'h0000;
    for (int k = 0; k < 5; k++) begin
      cyc();
      vga_rd_req  = 1'b1;
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = fill_addr[k];
      cpu_wr_data = fill_data[k];
      #2;
      chk("fill_ready", cpu_wr_ready, (k < 4) ? 1 : 0);
      chk("fill_level", fifo_level, (k < 4) ? k : 4);
      chk("fill_no_we", mem_we, 0);
    end
    cyc();
    cpu_wr_req = 1'b0;
    #2;
    chk("full_level", fifo_level, 4);
    chk("full_ready", cpu_wr_ready, 0);
    cyc();
    vga_rd_req = 1'b0;
    #2;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we",    mem_we, 1);
      chk("drain_addr",  mem_addr, fill_addr[i]);
      chk("drain_data",  mem_wdata, fill_data[i]);
      chk("drain_level", fifo_level, 4 - i);
      cyc();
      #2;
    end
    chk("drained_level", fifo_level, 0);
    chk("drained_en",    mem_en, 0);
    chk("drained_ready", cpu_wr_ready, 1);
    for (int i = 0; i < 4; i++) begin
      chk("fill_ram", ram[fill_addr[i]], fill_data[i]);
    end
    chk("fill_rejected_ram", ram[15'h0104], 0);

    // ---------------- read after write ----------------
    cyc();
    cpu_wr_req  = 1'b1;
    cpu_wr_addr = 15'h0A05;
    cpu_wr_data = 1'b1;
    #2;
    chk("raw_no_bypass", mem_en, 0);
    cyc();
    cpu_wr_req  = 1'b0;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 15'h0A05;
    #2;
    chk("raw_level",      fifo_level, 1);
    chk("raw_drain_we",   mem_we, 1);
    chk("raw_drain_addr", mem_addr, 15'h0A05);
    cyc();
    #2;
    chk("raw_rd_en",    mem_en, 1);
    chk("raw_rd_we",    mem_we, 0);
    chk("raw_rd_addr",  mem_addr, 15'h0A05);
    chk("raw_no_valid", cpu_rd_valid, 0);
    cyc();
    #2;
    chk("raw_valid",     cpu_rd_valid, 1);
    chk("raw_data",      cpu_rd_data, 1);
    chk("raw_no_regrant", mem_en, 0);
    cyc();
    cpu_rd_req = 1'b0;
    #2;
    chk("raw_valid_once", cpu_rd_valid, 0);

    // ---------------- VGA / CPU read contention ----------------
    cyc();
    vga_rd_req  = 1'b1;
    vga_rd_addr = 15'h0101;
    cpu_rd_req  = 1'b1;
    cpu_rd_addr = 15'h0102;
    #2;
    chk("cont_vga_addr", mem_addr, 15'h0101);
    chk("cont_vga_we",   mem_we, 0);
    cyc();
    vga_rd_req = 1'b0;
    #2;
    chk("cont_vga_valid", vga_rd_valid, 1);
    chk("cont_vga_data",  vga_rd_data, 0);
    chk("cont_cpu_wait",  cpu_rd_valid, 0);
    chk("cont_cpu_en",    mem_en, 1);
    chk("cont_cpu_addr",  mem_addr, 15'h0102);
    cyc();
    #2;
    chk("cont_cpu_valid", cpu_rd_valid, 1);
    chk("cont_cpu_data",  cpu_rd_data, 1);
    chk("cont_vga_quiet", vga_rd_valid, 0);
    cyc();
    cpu_rd_req = 1'b0;
    #2;
    chk("cont_cpu_once", cpu_rd_valid, 0);

    // ---------------- simultaneous push and pop, pointer wrap ----------------
    for (int k = 0; k < 4; k++) begin
      cyc();
      vga_rd_req  = (k < 2);
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = pp_addr[k];
      cpu_wr_data = pp_data[k];
      #2;
      chk("pp_level", fifo_level, (k < 2) ? k : 2);
      if (k >= 2) begin
        chk("pp_drain_addr", mem_addr, pp_addr[k-2]);
        chk("pp_drain_data", mem_wdata, pp_data[k-2]);
      end
    end
    cyc();
    cpu_wr_req = 1'b0;
    #2;
    chk("pp_tail_level", fifo_level, 2);
    chk("pp_tail_addr2", mem_addr, pp_addr[2]);
    cyc();
    #2;
    chk("pp_tail_level1", fifo_level, 1);
    chk("pp_tail_addr3",  mem_addr, pp_addr[3]);
    chk("pp_tail_data3",  mem_wdata, pp_data[3]);
    cyc();
    #2;
    chk("pp_empty", fifo_level, 0);
    for (int i = 0; i < 4; i++) begin
      chk("pp_ram", ram[pp_addr[i]], pp_data[i]);
    end

    // ---------------- reset mid-drain ----------------
    for (int k = 0; k < 3; k++) begin
      cyc();
      vga_rd_req  = 1'b1;
      cpu_wr_req  = 1'b1;
      cpu_wr_addr = 15'h0300 + ADDR_W'(k);
      cpu_wr_data = 1'b1;
      #2;
      chk("rd_fill_level", fifo_level, k);
    end
    cyc();
    cpu_wr_req = 1'b0;
    vga_rd_req = 1'b0;
    #2;
    chk("rd_pre_level", fifo_level, 3);
    chk("rd_pre_we",    mem_we, 1);
    wr_snap = wr_count;
    #1;
    rst_n = 1'b0;
    #1;
    chk("rd_level",     fifo_level, 0);
    chk("rd_ready",     cpu_wr_ready, 1);
    chk("rd_mem_en",    mem_en, 0);
    chk("rd_vga_valid", vga_rd_valid, 0);
    cyc();
    rst_n = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rd_post_en",    mem_en, 0);
      chk("rd_post_vga",   vga_rd_valid, 0);
      chk("rd_post_cpu",   cpu_rd_valid, 0);
      chk("rd_post_level", fifo_level, 0);
      cyc();
      #2;
    end
    chk("rd_no_writes", wr_count - wr_snap, 0);
    for (int i = 0; i < 3; i++) begin
      chk("rd_ram_untouched", ram[15'h0300 + ADDR_W'(i)], 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fb_access_arbiter.md
# fb_access_arbiter

Single-port frame-buffer access arbiter placed between the VGA scan-out reader, the CPU bus interface of the graphics peripheral, and the frame-buffer RAM. It shares the one RAM port between three requesters: VGA pixel reads (highest priority), CPU reads, and CPU writes. CPU writes are posted into a small write FIFO and drained into idle RAM cycles, so scan-out never stalls. It also enforces read-after-write ordering for the CPU.

## Interface
- ADDR_W, 15, frame-buffer address width; {y[6:0], x[7:0]}
- DATA_W, 1, pixel data width
- FIFO_DEPTH, 4, posted-write FIFO entries; power of two, at least 2
- CLK  in  1  system clock; all logic on the rising edge
- RESET  in  1  asynchronous, active-low reset
- vga_rd_req  in  1  single-cycle pixel read request
- vga_rd_addr  in  ADDR_W  pixel address, valid with vga_rd_req
- vga_rd_data  out  DATA_W  pixel data, valid with vga_rd_valid
- vga_rd_valid  out  1  one-cycle response strobe
- cpu_wr_req  in  1  write request; accepted when cpu_wr_ready is high
- cpu_wr_addr  in  ADDR_W  write address
- cpu_wr_data  in  DATA_W  write data
- cpu_wr_ready  out  1  FIFO not full
- cpu_rd_req  in  1  level request; held until cpu_rd_valid
- cpu_rd_addr  in  ADDR_W  read address; stable while cpu_rd_req is high
- cpu_rd_data  out  DATA_W  read data, valid with cpu_rd_valid
- cpu_rd_valid  out  1  one-cycle response strobe
- mem_en, mem_we  out  1  RAM enable and write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data; synchronous, one-cycle latency
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

## Operation
- Grant is decided combinationally each cycle from the current requests and FIFO state. Fixed priority:
  1. **VGA**: vga_rd_req is high.
  2. **CPU_RD**: cpu_rd_req is high, the FIFO is empty, and no CPU read is outstanding.
  3. **DRAIN**: the FIFO is not empty.
  4. **IDLE**: none of the above.
- RAM drive per grant:
  - VGA and CPU_RD drive mem_en=1, mem_we=0 and the requester's address.
  - DRAIN drives mem_en=1, mem_we=1, and the FIFO head address and data, then pops the head.
  - IDLE drives mem_en=0; mem_addr and mem_wdata hold their previous values.
- Read ordering: a CPU read is held off until the FIFO is empty. The CPU therefore always reads back its own earlier writes.
- The owner of each read is registered (NONE, VGA or CPU) for the response cycle:
  - vga_rd_data and cpu_rd_data pass mem_rdata straight through.
  - Each valid strobe is high only when its owner matches.
- An outstanding-CPU-read flag is set when CPU_RD is granted and cleared when cpu_rd_valid is issued. This prevents a held cpu_rd_req from being granted twice.
- FIFO behaviour:
  - Push when cpu_wr_req && cpu_wr_ready.
  - A simultaneous push and pop leaves the level unchanged.
  - cpu_wr_ready = (level != FIFO_DEPTH). There is no bypass path, so a write never reaches the RAM in its accept cycle.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally. The level counter is one bit wider.

## Timing
- Reset values:
  - vga_rd_valid, cpu_rd_valid, mem_en, mem_we: 0
  - fifo_level: 0; cpu_wr_ready: 1
  - mem_addr, mem_wdata: 0
  - owner: NONE; outstanding flag: 0
- Reset asserted mid-operation discards all FIFO contents and any in-flight read response. No valid strobe follows reset.
- VGA latency: a request in cycle N gives vga_rd_valid in cycle N+1, always. VGA is never stalled.
- CPU read latency: grant in cycle G gives cpu_rd_valid in cycle G+1. G is the first cycle in which vga_rd_req is low and the FIFO is empty.
- Write drain: an entry accepted in cycle N reaches the RAM no earlier than N+1, in the first non-VGA cycle.
- Back-to-back VGA requests every cycle starve both CPU paths indefinitely. This is accepted; scan-out issues at most one request per pixel-clock enable.

## Structure
- Package fb_arb_pkg holds:
  - the owner enum (OWN_NONE, OWN_VGA, OWN_CPU)
  - the grant enum (G_IDLE, G_VGA, G_CPU_RD, G_DRAIN)
  - default ADDR_W/DATA_W constants
- Sub-module fb_wr_fifo: synchronous FIFO of {addr, data} with push, pop, full, empty and level outputs. Write logic is in the arbiter top.

## Test plan
- **VGA only.** Preload RAM[0x0123]=1. Pulse vga_rd_req with addr 0x0123 in cycle 10. Expect vga_rd_valid=1 and vga_rd_data=1 in cycle 11 only; cpu_rd_valid stays 0.
- **FIFO fill.** Issue 5 CPU writes in consecutive cycles while vga_rd_req is held high. Expect 4 accepted, cpu_wr_ready=0 after the 4th, fifo_level=4. Release VGA; the 4 writes drain one per cycle in order and fifo_level returns to 0.
- **Read-after-write.** Write 1 to 0x0A05, then immediately assert cpu_rd_req for 0x0A05. Expect the drain before the read grant, and cpu_rd_valid with data 1.
- **Contention.** VGA and CPU read requests in the same cycle with the FIFO empty. Expect the VGA response at N+1 and the CPU response at N+2.
- **Push and pop.** With fifo_level=2, push in the same cycle as a drain. Expect fifo_level to stay 2 and pointers to wrap correctly past index 3.
- **Reset mid-drain.** With fifo_level=3, pull RESET low for one cycle. Expect fifo_level=0, cpu_wr_ready=1 and mem_en=0 asynchronously, and no further RAM writes.
